mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port synchronous memory.
// One transaction in flight at a time: accept, issue, wait for read data, respond.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              store_q, store_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              sel_d, sel_if, idle_ok;

  // On a tie, data wins under fixed priority or when fetch had the previous grant.
  always_comb begin
    sel_d   = d_req_valid && (!if_req_valid || DATA_PRIORITY || (last_grant_q == OWN_IF));
    sel_if  = if_req_valid && !sel_d;
    idle_ok = (state_q == S_IDLE) && reset_n;
    if_req_ready = idle_ok && sel_if;
    d_req_ready  = idle_ok && sel_d;
  end

  always_comb begin
    // NOTE: every _d defaults to hold (or to the idle pulse value) first, so no path infers a latch.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    store_d        = store_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 4'b0000;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rsp_valid_d = 1'b0;
    d_rsp_valid_d  = 1'b0;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_d || sel_if) begin
          owner_d      = sel_d ? OWN_D : OWN_IF;
          last_grant_d = sel_d ? OWN_D : OWN_IF;
          store_d      = sel_d && d_we;
          mem_en_d     = 1'b1;
          mem_addr_d   = sel_d ? d_addr : if_addr;
          if (sel_d && d_we) begin
            mem_we_d    = d_wstrb;
            mem_wdata_d = d_wdata;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (owner_q == OWN_D) begin
          d_rdata_d     = store_q ? 32'h0 : mem_rdata;
          d_rsp_valid_d = 1'b1;
        end else begin
          if_rdata_d     = mem_rdata;
          if_rsp_valid_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= OWN_D;
      owner_q        <= OWN_IF;
      store_q        <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 4'b0000;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'h0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rdata_q     <= 32'h0;
      d_rdata_q      <= 32'h0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      store_q        <= store_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a data-priority instance
// share request stimulus; each has its own behavioural synchronous memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid, d_req_valid, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic        if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  logic        dp_if_req_ready, dp_d_req_ready, dp_if_rsp_valid, dp_d_rsp_valid, dp_mem_en;
  logic [31:0] dp_if_rdata, dp_d_rdata, dp_mem_addr, dp_mem_wdata, dp_mem_rdata;
  logic [3:0]  dp_mem_we;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_PRIORITY(1'b1)) u_dp (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(dp_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(dp_if_rsp_valid), .if_rdata(dp_if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(dp_d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rsp_valid(dp_d_rsp_valid), .d_rdata(dp_d_rdata),
    .mem_en(dp_mem_en), .mem_we(dp_mem_we), .mem_addr(dp_mem_addr), .mem_wdata(dp_mem_wdata),
    .mem_rdata(dp_mem_rdata)
  );

  // Memory contents are a fixed function of address; reads return one cycle after mem_en.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0040: mem_fn = 32'h0050_0093;
      32'h0000_0008: mem_fn = 32'h1111_1111;
      default:       mem_fn = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en)    mem_rdata    <= mem_fn(mem_addr);
    if (dp_mem_en) dp_mem_rdata <= mem_fn(dp_mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_addr = 32'h0;
    d_req_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h40;
    d_req_valid = 1'b1; d_addr = 32'h8;
    tick(); tick();
    n_cmp++; if (if_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_if_ready: got %b want 0", if_req_ready); end
    n_cmp++; if (d_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready: got %b want 0", d_req_ready); end
    n_cmp++; if ({mem_en, mem_we} !== 5'b0) begin n_bad++; $display("FAIL rst_mem_en_we: got %b want 0", {mem_en, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_bad++; $display("FAIL rst_mem_addr_wdata: got %h want 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ({if_rsp_valid, d_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", {if_rsp_valid, d_rsp_valid}); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
    idle_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req_valid = 1'b1; if_addr = 32'h40;
    #1;
    n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready: got %b want 1", if_req_ready); end
    n_cmp++; if (d_req_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ready: got %b want 0", d_req_ready); end
    tick(); if_req_valid = 1'b0;
    n_cmp++; if ({mem_en, mem_we} !== 5'b1_0000) begin n_bad++; $display("FAIL fetch_issue_en_we: got %b want 10000", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL fetch_issue_addr: got %h want 00000040", mem_addr); end
    tick();
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL fetch_wait_en: got %b want 0", mem_en); end
    tick();
    n_cmp++; if (if_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_rsp_valid: got %b want 1", if_rsp_valid); end
    n_cmp++; if (if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
    n_cmp++; if (d_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_d_rsp: got %b want 0", d_rsp_valid); end
    tick();
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_rsp_pulse: got %b want 0", if_rsp_valid); end
  endtask

  // Fetch had the last grant, so the tie goes to data here.
  task automatic test_load_then_fetch();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    if_req_valid = 1'b1; if_addr = 32'h40;
    #1;
    n_cmp++; if ({d_req_ready, if_req_ready} !== 2'b10) begin n_bad++; $display("FAIL ld_grant: got d/if %b want 10", {d_req_ready, if_req_ready}); end
    tick(); d_req_valid = 1'b0;
    n_cmp++; if (mem_addr !== 32'h8) begin n_bad++; $display("FAIL ld_issue_addr: got %h want 00000008", mem_addr); end
    tick(); tick();
    n_cmp++; if (d_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL ld_rsp_valid: got %b want 1", d_rsp_valid); end
    n_cmp++; if (d_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL ld_rdata: got %h want 11111111", d_rdata); end
    n_cmp++; if (if_req_ready !== 1'b0) begin n_bad++; $display("FAIL ld_resp_ready: got %b want 0", if_req_ready); end
    tick();
    n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_fetch_ready: got %b want 1", if_req_ready); end
    tick(); if_req_valid = 1'b0;
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL b2b_fetch_addr: got %h want 00000040", mem_addr); end
    tick(); tick();
    n_cmp++; if (if_rsp_valid !== 1'b1 || if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL b2b_fetch_rsp: got %b/%h want 1/00500093", if_rsp_valid, if_rdata); end
    n_cmp++; if (d_rdata !== 32'h1111_1111 || d_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_d_hold: got %b/%h want 0/11111111", d_rsp_valid, d_rdata); end
    tick();
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    #1;
    n_cmp++; if (d_req_ready !== 1'b1) begin n_bad++; $display("FAIL st_ready: got %b want 1", d_req_ready); end
    tick(); d_req_valid = 1'b0;
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== wstrb) begin n_bad++; $display("FAIL st_issue_en_we: got %b/%b want 1/%b", mem_en, mem_we, wstrb); end
    n_cmp++; if (mem_addr !== addr || mem_wdata !== wdata) begin n_bad++; $display("FAIL st_issue_addr_data: got %h/%h want %h/%h", mem_addr, mem_wdata, addr, wdata); end
    tick();
    n_cmp++; if ({mem_en, mem_we} !== 5'b0) begin n_bad++; $display("FAIL st_wait_en_we: got %b want 0", {mem_en, mem_we}); end
    tick();
    n_cmp++; if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL st_ack: got %b/%h want 1/00000000", d_rsp_valid, d_rdata); end
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL st_if_rsp: got %b want 0", if_rsp_valid); end
    tick();
    n_cmp++; if (d_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL st_ack_pulse: got %b want 0", d_rsp_valid); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_if;
    reset_pulse();
    if_req_valid = 1'b1; if_addr = 32'h40;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_if = (k % 2 == 0);
      n_cmp++; if ({if_req_ready, d_req_ready} !== {exp_if, !exp_if}) begin n_bad++; $display("FAIL rr_grant%0d: got if/d %b want %b", k, {if_req_ready, d_req_ready}, {exp_if, !exp_if}); end
      tick();
      n_cmp++; if (mem_addr !== (exp_if ? 32'h40 : 32'h8)) begin n_bad++; $display("FAIL rr_addr%0d: got %h want %h", k, mem_addr, exp_if ? 32'h40 : 32'h8); end
      tick(); tick();
      n_cmp++; if ({if_rsp_valid, d_rsp_valid} !== {exp_if, !exp_if}) begin n_bad++; $display("FAIL rr_rsp%0d: got if/d %b want %b", k, {if_rsp_valid, d_rsp_valid}, {exp_if, !exp_if}); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_data_priority();
    reset_pulse();
    if_req_valid = 1'b1; if_addr = 32'h40;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1;
    n_cmp++; if ({dp_d_req_ready, dp_if_req_ready} !== 2'b10) begin n_bad++; $display("FAIL dp_grant0: got d/if %b want 10", {dp_d_req_ready, dp_if_req_ready}); end
    tick();
    n_cmp++; if (dp_mem_addr !== 32'h8) begin n_bad++; $display("FAIL dp_addr0: got %h want 00000008", dp_mem_addr); end
    tick(); tick();
    n_cmp++; if ({dp_d_rsp_valid, dp_if_rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL dp_rsp0: got d/if %b want 10", {dp_d_rsp_valid, dp_if_rsp_valid}); end
    tick();
    n_cmp++; if ({dp_d_req_ready, dp_if_req_ready} !== 2'b10) begin n_bad++; $display("FAIL dp_grant1: got d/if %b want 10", {dp_d_req_ready, dp_if_req_ready}); end
    tick(); d_req_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (dp_d_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL dp_rsp1: got %b want 1", dp_d_rsp_valid); end
    tick();
    n_cmp++; if ({dp_d_req_ready, dp_if_req_ready} !== 2'b01) begin n_bad++; $display("FAIL dp_grant2: got d/if %b want 01", {dp_d_req_ready, dp_if_req_ready}); end
    tick(); if_req_valid = 1'b0;
    n_cmp++; if (dp_mem_addr !== 32'h40) begin n_bad++; $display("FAIL dp_addr2: got %h want 00000040", dp_mem_addr); end
    tick(); tick();
    n_cmp++; if (dp_if_rsp_valid !== 1'b1 || dp_if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL dp_rsp2: got %b/%h want 1/00500093", dp_if_rsp_valid, dp_if_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int d_seen;
    d_seen = 0;
    reset_pulse();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    #1;
    n_cmp++; if (d_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", d_req_ready); end
    tick(); d_req_valid = 1'b0;
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin n_bad++; $display("FAIL mid_issue: got %b/%h want 1/00000200", mem_en, mem_addr); end
    tick();
    if_req_valid = 1'b1; if_addr = 32'h40;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_mem: got %b/%h want 0/00000000", mem_en, mem_addr); end
    n_cmp++; if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid} !== 4'b0) begin n_bad++; $display("FAIL mid_rst_hs: got %b want 0000", {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid}); end
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (if_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_post_ready: got %b want 1", if_req_ready); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) if_req_valid = 1'b0;
      if (d_rsp_valid !== 1'b0) d_seen++;
      if (c == 3) begin
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL mid_post_fetch: got %b/%h want 1/00500093", if_rsp_valid, if_rdata); end
      end
    end
    n_cmp++; if (d_seen !== 0) begin n_bad++; $display("FAIL mid_dropped_rsp: got %0d d_rsp pulses want 0", d_seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_load_then_fetch();
    test_store(32'h104, 32'hDEAD_BEEF, 4'b0011);
    test_store(32'h10, 32'h1234_5678, 4'b0000);
    test_round_robin();
    test_data_priority();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
